conv_out_collector: RTL and testbench
=====================================

// Module: conv_out_collector
// PURPOSE
//  Downstream of the 5-PE filter-row array chain. Takes the final partial-sum
//  stream (Po of the last row) and keeps only valid KxK window positions.
//  Adds a per-map bias with saturation, applies optional ReLU, and buffers the
//  results in a small FIFO with a valid/ready handshake toward the pooling
//  stage. Also flags the end of each output feature map.
// PARAMETERS
//  M      32  data width, signed two's complement
//  N      0   fractional bits; carried through only, the block never rescales
//  IMG_W  32  input map width and height in pixels
//  K      5   kernel size; output map is (IMG_W-K+1)^2
//  RELU   1   1: clamp negative results to 0; 0: pass through
//  DEPTH  4   output FIFO depth (power of 2)
// PORTS
//  clk        in   1   clock, rising edge
//  rst        in   1   asynchronous active-low reset
//  start      in   1   1-cycle pulse: latch bias_in, clear counters, enter RUN
//  bias_in    in   M   per-map bias, sampled when start=1
//  p_in       in   M   partial sum from the last filter row
//  p_valid    in   1   p_in is valid this cycle
//  p_ready    out  1   block accepts p_in; equals !fifo_full while in RUN
//  o_data     out  M   biased, saturated, activated result (FIFO head)
//  o_valid    out  1   o_data is valid
//  o_ready    in   1   consumer accepts o_data
//  map_done   out  1   1-cycle pulse when the last output of the map is pushed
//  busy       out  1   high in RUN
// BEHAVIOUR
//  Reset (rst=0, async): state=IDLE, col=row=0, bias=0, FIFO empty.
//   All outputs are 0 (p_ready, o_valid, map_done, busy, o_data).
//  FSM:
//   IDLE -start-> RUN (counters cleared, bias latched).
//   RUN: on the accept of the last input pixel (row=col=IMG_W-1), go to DONE.
//   DONE -> IDLE after 1 cycle.
//   A start pulse received in RUN or DONE restarts the map: counters cleared,
//    bias reloaded, FIFO contents kept.
//  Input accept = p_valid & p_ready. Only accepted beats advance the counters.
//   col increments; at col=IMG_W-1 it wraps to 0 and row increments.
//  Keep rule: a beat is kept iff col>=K-1 and row>=K-1. Other beats are
//   dropped silently.
//  Arithmetic: sum = p_in + bias computed at M+1 bits, then saturated to
//   [-2^(M-1), 2^(M-1)-1]. With RELU=1 a negative sum becomes 0.
//  Pipeline: the kept result is registered one stage and pushed into the FIFO
//   1 cycle after input accept. First o_valid appears 2 cycles after accept
//   when the FIFO is empty.
//  p_ready=0 in IDLE/DONE, and when the FIFO holds >= DEPTH-1 entries. The
//   threshold leaves room for the in-flight pipeline register.
//  FIFO: push and pop in the same cycle keep the count unchanged; the FIFO
//   never overflows or underflows. o_data is held stable while o_valid=1 and
//   o_ready=0.
//  map_done pulses in the cycle of the push of output (IMG_W-K, IMG_W-K),
//   independent of o_ready.
//  busy=1 exactly in RUN.
//  Asserting rst mid-map discards the FIFO and the pipeline register.
// TESTING
//  1. Reset mid-stream (rst=0 with 3 entries buffered) -> o_valid=0,
//     p_ready=0, FIFO empty; after release, state IDLE.
//  2. IMG_W=32, K=5, RELU=0, bias=0, p_in = row*32+col, o_ready=1 ->
//     exactly 784 outputs; first output = 132, last = 1023; one map_done
//     pulse on the 784th push.
//  3. Saturation: bias=0x7FFFFFF0, p_in=0x100 -> o_data=0x7FFFFFFF.
//     Then bias=0x80000000, p_in=-1 -> o_data=0x80000000.
//  4. RELU=1, bias=-10, p_in=5 -> 0; p_in=15 -> 5.
//  5. Backpressure: o_ready=0 with continuous p_valid -> p_ready falls once the
//     FIFO holds 3 entries, no data lost. Then o_ready=1 -> outputs drain in
//     order with o_data stable while stalled.
//  6. start re-pulsed at row 10 -> counters restart; the next kept output is
//     the new map's (4,4) position with the new bias.

Source files
------------

// File: rtl/conv_out_collector_if.sv
// Stream bundle around the output collector: the partial-sum input stream
// from the last filter row and the result stream toward the pooling stage.
// The master side produces p_in and consumes o_data; the slave is the collector.
interface conv_out_collector_if #(
    parameter int M = 32
);
    logic [M-1:0] p_in;
    logic         p_valid;
    logic         p_ready;
    logic [M-1:0] o_data;
    logic         o_valid;
    logic         o_ready;

    modport master (
        output p_in,
        output p_valid,
        output o_ready,
        input  p_ready,
        input  o_data,
        input  o_valid
    );

    modport slave (
        input  p_in,
        input  p_valid,
        input  o_ready,
        output p_ready,
        output o_data,
        output o_valid
    );
endinterface

// File: rtl/conv_out_collector.sv
// Output collector for the filter-row array chain.
// Walks the incoming partial-sum raster, keeps only beats where a full KxK
// window fits, adds the per-map bias with saturation, optionally clamps
// negatives, and queues results in a small FIFO toward the pooling stage.
// map_done marks the push of the last output of a map.
module conv_out_collector #(
    parameter int M     = 32,
    parameter int N     = 0,
    parameter int IMG_W = 32,
    parameter int K     = 5,
    parameter int RELU  = 1,
    parameter int DEPTH = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [M-1:0]         bias_in,
    conv_out_collector_if.slave  bus,
    output logic                 map_done,
    output logic                 busy
);
    localparam int CW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [CW-1:0] LAST_POS    = CW'(IMG_W - 1);
    localparam logic [CW-1:0] KEEP_POS    = CW'(K - 1);
    localparam logic [AW:0]   READY_LIMIT = (AW + 1)'(DEPTH - 1);
    localparam logic [M-1:0]  SAT_MAX     = {1'b0, {(M-1){1'b1}}};
    localparam logic [M-1:0]  SAT_MIN     = {1'b1, {(M-1){1'b0}}};

    // Fractional bits only ride along with the data; they must fit the word.
    generate
        if (N < 0 || N >= M) begin : g_bad_frac
            $error("conv_out_collector: N must be in [0, M-1]");
        end
    endgenerate

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t         state_reg;
    logic           busy_reg;
    logic [CW-1:0]  col_reg;
    logic [CW-1:0]  row_reg;
    logic [M-1:0]   bias_reg;
    logic           pipe_valid_reg;
    logic [M-1:0]   pipe_data_reg;
    logic           map_done_reg;
    logic [M-1:0]   mem_reg [DEPTH];
    logic [AW-1:0]  wr_ptr_reg;
    logic [AW-1:0]  rd_ptr_reg;
    logic [AW:0]    count_reg;

    logic           in_ready;
    logic           accept;
    logic           last_px;
    logic           keep;
    logic           push;
    logic           pop;
    logic           fifo_nonempty;
    logic [M:0]     sum_ext;
    logic [M-1:0]   sat_val;
    logic [M-1:0]   act_val;

    // One slot is held back so the beat already in the pipeline register
    // always finds room in the FIFO.
    assign in_ready      = (state_reg == S_RUN) && (count_reg < READY_LIMIT);
    assign accept        = bus.p_valid && in_ready;
    assign last_px       = (col_reg == LAST_POS) && (row_reg == LAST_POS);
    assign keep          = accept && (col_reg >= KEEP_POS) && (row_reg >= KEEP_POS);
    assign push          = pipe_valid_reg;
    assign fifo_nonempty = (count_reg != '0);
    assign pop           = fifo_nonempty && bus.o_ready;

    assign bus.p_ready = in_ready;
    assign bus.o_valid = fifo_nonempty;
    assign bus.o_data  = fifo_nonempty ? mem_reg[rd_ptr_reg] : '0;
    assign map_done    = map_done_reg;
    assign busy        = busy_reg;

    // Bias add one bit wider than the data, then clamp to the signed range
    // and optionally zero negative results.
    always_comb begin
        sum_ext = {bus.p_in[M-1], bus.p_in} + {bias_reg[M-1], bias_reg};
        sat_val = sum_ext[M-1:0];
        if (sum_ext[M] != sum_ext[M-1]) begin
            sat_val = sum_ext[M] ? SAT_MIN : SAT_MAX;
        end
        act_val = sat_val;
        if ((RELU != 0) && sat_val[M-1]) begin
            act_val = '0;
        end
    end

    // Map sequencing: a start pulse (re)enters RUN from any state; the accept
    // of the last raster pixel ends the map.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg <= S_IDLE;
            busy_reg  <= 1'b0;
        end else if (start) begin
            state_reg <= S_RUN;
            busy_reg  <= 1'b1;
        end else begin
            case (state_reg)
                S_RUN: begin
                    if (accept && last_px) begin
                        state_reg <= S_DONE;
                        busy_reg  <= 1'b0;
                    end
                end
                S_DONE: begin
                    state_reg <= S_IDLE;
                    busy_reg  <= 1'b0;
                end
                default: begin
                    state_reg <= S_IDLE;
                    busy_reg  <= 1'b0;
                end
            endcase
        end
    end

    // Raster position of the next input beat and the bias of the current map.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            col_reg  <= '0;
            row_reg  <= '0;
            bias_reg <= '0;
        end else if (start) begin
            col_reg  <= '0;
            row_reg  <= '0;
            bias_reg <= bias_in;
        end else if (accept) begin
            if (col_reg == LAST_POS) begin
                col_reg <= '0;
                row_reg <= row_reg + 1'b1;
            end else begin
                col_reg <= col_reg + 1'b1;
            end
        end
    end

    // Single result stage between the arithmetic and the FIFO; map_done is
    // raised alongside the last kept result so it coincides with its push.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pipe_valid_reg <= 1'b0;
            pipe_data_reg  <= '0;
            map_done_reg   <= 1'b0;
        end else begin
            pipe_valid_reg <= keep;
            map_done_reg   <= keep && last_px;
            if (keep) begin
                pipe_data_reg <= act_val;
            end
        end
    end

    // FIFO storage: written only at the tail, read combinationally at the head.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_reg[wr_ptr_reg] <= pipe_data_reg;
        end
    end

    // FIFO pointers and occupancy; a simultaneous push and pop leaves the
    // count unchanged.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
            case ({push, pop})
                2'b10:   count_reg <= count_reg + 1'b1;
                2'b01:   count_reg <= count_reg - 1'b1;
                default: count_reg <= count_reg;
            endcase
        end
    end
endmodule

// File: tb/tb_conv_out_collector.sv
// Bench for conv_out_collector: two instances (RELU off / on) driven in
// lockstep from one stimulus; a scoreboard queue per instance holds the
// expected outputs pushed when each input beat is accepted.
module tb_conv_out_collector;
    localparam int M     = 32;
    localparam int IMG_W = 32;
    localparam int K     = 5;
    localparam int NVEC  = 10;

    typedef struct {
        logic [31:0] bias;
        logic [31:0] pix;
        logic [31:0] exp_lin;
        logic [31:0] exp_relu;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [31:0] bias_in;
    logic [31:0] drv_p_in;
    logic        drv_p_valid;
    logic        drv_o_ready;
    logic        done_a, busy_a, done_b, busy_b;

    int          total = 0;
    int          bad = 0;
    int          m_row = 0;
    int          m_col = 0;
    logic [31:0] m_bias = '0;
    logic [31:0] qa[$];
    logic [31:0] qb[$];
    bit          done_arm = 1'b0;
    bit          done_exp = 1'b0;
    int          n_out_a = 0;
    int          n_done_a = 0;
    logic [31:0] last_out_a = '0;
    bit          stall_a = 1'b0;
    bit          stall_b = 1'b0;
    logic [31:0] hold_a = '0;
    logic [31:0] hold_b = '0;
    vec_t        vecs[NVEC];

    always #5 clk = ~clk;

    conv_out_collector_if #(.M(M)) bus_a ();
    conv_out_collector_if #(.M(M)) bus_b ();

    assign bus_a.p_in    = drv_p_in;
    assign bus_a.p_valid = drv_p_valid;
    assign bus_a.o_ready = drv_o_ready;
    assign bus_b.p_in    = drv_p_in;
    assign bus_b.p_valid = drv_p_valid;
    assign bus_b.o_ready = drv_o_ready;

    conv_out_collector #(.M(M), .N(0), .IMG_W(IMG_W), .K(K), .RELU(0), .DEPTH(4)) dut_a (
        .clk(clk), .rst(rst), .start(start), .bias_in(bias_in),
        .bus(bus_a), .map_done(done_a), .busy(busy_a)
    );

    conv_out_collector #(.M(M), .N(0), .IMG_W(IMG_W), .K(K), .RELU(1), .DEPTH(4)) dut_b (
        .clk(clk), .rst(rst), .start(start), .bias_in(bias_in),
        .bus(bus_b), .map_done(done_b), .busy(busy_b)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h, required %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] sat_add(input logic [31:0] a, input logic [31:0] b);
        longint s;
        s = longint'($signed(a)) + longint'($signed(b));
        if (s > 64'sd2147483647) return 32'h7FFF_FFFF;
        if (s < -64'sd2147483648) return 32'h8000_0000;
        return s[31:0];
    endfunction

    function automatic logic [31:0] relu(input logic [31:0] x);
        return x[31] ? 32'h0 : x;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Called in the accept cycle: queue expectations, advance the raster model.
    task automatic model_accept(input logic [31:0] d, input bit use_tab,
                                input logic [31:0] ta, input logic [31:0] tb);
        logic [31:0] e;
        if (m_row >= K - 1 && m_col >= K - 1) begin
            if (use_tab) begin
                qa.push_back(ta);
                qb.push_back(tb);
            end else begin
                e = sat_add(d, m_bias);
                qa.push_back(e);
                qb.push_back(relu(e));
            end
            if (m_row == IMG_W - 1 && m_col == IMG_W - 1) done_arm = 1'b1;
        end
        if (m_col == IMG_W - 1) begin
            m_col = 0;
            m_row++;
        end else begin
            m_col++;
        end
    endtask

    task automatic do_start(input logic [31:0] b);
        start   = 1'b1;
        bias_in = b;
        tick();
        start   = 1'b0;
        m_row   = 0;
        m_col   = 0;
        m_bias  = b;
    endtask

    task automatic drive_beat(input logic [31:0] d, input bit use_tab,
                              input logic [31:0] ta, input logic [31:0] tb);
        int n;
        bit got;
        n = 0;
        got = 1'b0;
        drv_p_valid = 1'b1;
        drv_p_in = d;
        while (!got && n < 100) begin
            @(negedge clk);
            if (bus_a.p_ready) got = 1'b1;
            else n++;
        end
        if (!got) begin
            total++;
            bad++;
            $display("FAIL accept_timeout: p_ready low for %0d cycles, required high", n);
        end else begin
            model_accept(d, use_tab, ta, tb);
        end
        tick();
        drv_p_valid = 1'b0;
    endtask

    // pattern=1 sends the raster index row*IMG_W+col, otherwise random data.
    task automatic drive_n(input int cnt, input bit pattern);
        logic [31:0] d;
        for (int i = 0; i < cnt; i++) begin
            d = pattern ? 32'(m_row * IMG_W + m_col) : $urandom;
            drive_beat(d, 1'b0, 32'h0, 32'h0);
        end
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while ((qa.size() != 0 || qb.size() != 0) && n < 500) begin
            tick();
            n++;
        end
        if (n >= 500) begin
            total++;
            bad++;
            $display("FAIL drain_timeout: %0d/%0d outputs still pending, required 0", qa.size(), qb.size());
        end
        tick();
        tick();
    endtask

    // map_done is due in the cycle after the accept of the last pixel.
    always @(posedge clk) begin
        done_exp = done_arm;
        done_arm = 1'b0;
    end

    // Output monitor: scoreboard pops, hold-while-stalled and map_done checks.
    always @(negedge clk) begin
        if (!rst) begin
            stall_a = 1'b0;
            stall_b = 1'b0;
        end else begin
            if (stall_a) begin
                chk("hold_valid_a", 32'(bus_a.o_valid), 32'd1);
                chk("hold_data_a", bus_a.o_data, hold_a);
            end
            if (stall_b) begin
                chk("hold_valid_b", 32'(bus_b.o_valid), 32'd1);
                chk("hold_data_b", bus_b.o_data, hold_b);
            end
            if (bus_a.o_valid && drv_o_ready) begin
                if (qa.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL out_a: got unexpected %h, required no output", bus_a.o_data);
                end else begin
                    chk("out_a", bus_a.o_data, qa.pop_front());
                end
                n_out_a++;
                last_out_a = bus_a.o_data;
            end
            if (bus_b.o_valid && drv_o_ready) begin
                if (qb.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL out_b: got unexpected %h, required no output", bus_b.o_data);
                end else begin
                    chk("out_b", bus_b.o_data, qb.pop_front());
                end
            end
            stall_a = bus_a.o_valid && !drv_o_ready;
            stall_b = bus_b.o_valid && !drv_o_ready;
            hold_a  = bus_a.o_data;
            hold_b  = bus_b.o_data;
            chk("map_done_a", 32'(done_a), 32'(done_exp));
            chk("map_done_b", 32'(done_b), 32'(done_exp));
            if (done_a) n_done_a++;
        end
    end

    initial begin
        int n0;
        int d0;
        int acc;

        vecs[0] = '{32'h7FFF_FFF0, 32'h0000_0100, 32'h7FFF_FFFF, 32'h7FFF_FFFF};
        vecs[1] = '{32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'h0000_0000};
        vecs[2] = '{32'hFFFF_FFF6, 32'h0000_0005, 32'hFFFF_FFFB, 32'h0000_0000};
        vecs[3] = '{32'hFFFF_FFF6, 32'h0000_000F, 32'h0000_0005, 32'h0000_0005};
        vecs[4] = '{32'h0000_0000, 32'h0000_0000, 32'h0000_0000, 32'h0000_0000};
        vecs[5] = '{32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h7FFF_FFFF};
        vecs[6] = '{32'h8000_0000, 32'h8000_0000, 32'h8000_0000, 32'h0000_0000};
        vecs[7] = '{32'h0000_0064, 32'hFFFF_FFCE, 32'h0000_0032, 32'h0000_0032};
        vecs[8] = '{32'h4000_0000, 32'h3FFF_FFFF, 32'h7FFF_FFFF, 32'h7FFF_FFFF};
        vecs[9] = '{32'hC000_0000, 32'hBFFF_FFFF, 32'h8000_0000, 32'h0000_0000};

        rst = 1'b0;
        start = 1'b0;
        bias_in = '0;
        drv_p_in = '0;
        drv_p_valid = 1'b0;
        drv_o_ready = 1'b0;

        // Reset state
        #2;
        chk("rst_o_valid_a", 32'(bus_a.o_valid), 32'd0);
        chk("rst_p_ready_a", 32'(bus_a.p_ready), 32'd0);
        chk("rst_busy_a", 32'(busy_a), 32'd0);
        chk("rst_map_done_a", 32'(done_a), 32'd0);
        chk("rst_o_data_a", bus_a.o_data, 32'd0);
        chk("rst_o_valid_b", 32'(bus_b.o_valid), 32'd0);
        chk("rst_p_ready_b", 32'(bus_b.p_ready), 32'd0);
        chk("rst_busy_b", 32'(busy_b), 32'd0);
        chk("rst_map_done_b", 32'(done_b), 32'd0);
        chk("rst_o_data_b", bus_b.o_data, 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        tick();

        // Reset mid-stream with three results buffered
        do_start(32'd0);
        drive_n(135, 1'b0);
        tick();
        tick();
        chk("pre_rst_o_valid", 32'(bus_a.o_valid), 32'd1);
        #2;
        rst = 1'b0;
        #1;
        chk("midrst_o_valid_a", 32'(bus_a.o_valid), 32'd0);
        chk("midrst_o_valid_b", 32'(bus_b.o_valid), 32'd0);
        chk("midrst_p_ready", 32'(bus_a.p_ready), 32'd0);
        chk("midrst_busy", 32'(busy_a), 32'd0);
        chk("midrst_o_data", bus_a.o_data, 32'd0);
        qa.delete();
        qb.delete();
        m_row = 0;
        m_col = 0;
        m_bias = '0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        tick();
        tick();
        chk("post_rst_busy", 32'(busy_a), 32'd0);
        chk("post_rst_p_ready", 32'(bus_a.p_ready), 32'd0);
        chk("post_rst_o_valid", 32'(bus_a.o_valid), 32'd0);
        drv_o_ready = 1'b1;

        // Arithmetic table: one kept beat at (4,4) per vector, start re-pulsed in RUN
        for (int i = 0; i < NVEC; i++) begin
            do_start(vecs[i].bias);
            drive_n(132, 1'b0);
            drive_beat(vecs[i].pix, 1'b1, vecs[i].exp_lin, vecs[i].exp_relu);
        end
        wait_drain();

        // Full map, raster-index data, zero bias
        n0 = n_out_a;
        d0 = n_done_a;
        do_start(32'd0);
        drive_n(IMG_W * IMG_W, 1'b1);
        wait_drain();
        chk("map_output_count", 32'(n_out_a - n0), 32'd784);
        chk("map_done_pulses", 32'(n_done_a - d0), 32'd1);
        chk("map_last_output", last_out_a, 32'd1023);
        chk("after_map_busy", 32'(busy_a), 32'd0);
        chk("after_map_p_ready", 32'(bus_a.p_ready), 32'd0);

        // Backpressure: stall the consumer inside the kept region
        do_start(32'd7);
        drive_n(132, 1'b0);
        drv_o_ready = 1'b0;
        drv_p_valid = 1'b1;
        acc = 0;
        for (int c = 0; c < 12; c++) begin
            drv_p_in = 32'(1000 + acc);
            @(negedge clk);
            if (bus_a.p_ready) begin
                model_accept(drv_p_in, 1'b0, 32'h0, 32'h0);
                acc++;
            end
            tick();
        end
        drv_p_valid = 1'b0;
        chk("bp_accepted", 32'(acc), 32'd4);
        chk("bp_p_ready_low", 32'(bus_a.p_ready), 32'd0);
        chk("bp_o_valid", 32'(bus_a.o_valid), 32'd1);
        repeat (3) tick();
        drv_o_ready = 1'b1;
        wait_drain();
        chk("bp_p_ready_back", 32'(bus_a.p_ready), 32'd1);

        // Restart at row 10 with a new bias
        do_start(32'd5);
        drive_n(10 * IMG_W, 1'b1);
        do_start(32'd1000);
        chk("restart_busy", 32'(busy_a), 32'd1);
        drive_n(133, 1'b1);
        wait_drain();
        chk("restart_first_kept", last_out_a, 32'd1132);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
